// File: rtl/steer_en_ctrl.sv
// ----------------------------------------------------------------------------
// steer_en_ctrl
//
// Rider-presence and steering-enable controller for the balance path.
// Watches the raw left/right load-cell readings and decides when a rider is
// standing on the platform, when the rider has settled evenly enough to hand
// control to balance_cntrl, and when the rider has stepped off.
// The settle timer and the step-off debounce counter are internal.
//
// Optional feature macro: STEER_FAULT_EN
//   defined   : a WAIT dwell counter raises a sticky 'fault' after
//               FAULT_CYCLES consecutive cycles in WAIT; cleared on return
//               to IDLE.
//   undefined : no dwell counter; 'fault' is constant 0.
//
// Ports:
//   clk        in   1       system clock (50 MHz)
//   rst_n      in   1       asynchronous active-low reset
//   lft_load   in   LOAD_W  left load cell reading, unsigned
//   rght_load  in   LOAD_W  right load cell reading, unsigned
//   en_steer   out  1       registered, high while in STEER
//   rider_off  out  1       registered one-cycle pulse on return to IDLE
//   state_o    out  2       current state: 0=IDLE, 1=WAIT, 2=STEER
//   fault      out  1       settle-timeout fault (0 without STEER_FAULT_EN)
// ----------------------------------------------------------------------------
module steer_en_ctrl #(
    parameter int LOAD_W           = 12,
    parameter int MIN_RIDER_WEIGHT = 'h200,
    parameter int HYSTERESIS       = 'h020,
    parameter int SETTLE_SHIFT     = 2,
    parameter int TMR_CYCLES       = 65_000_000,
    parameter int OFF_DBNC         = 4,
    parameter int FAULT_CYCLES     = 250_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LOAD_W-1:0] lft_load,
    input  logic [LOAD_W-1:0] rght_load,
    output logic              en_steer,
    output logic              rider_off,
    output logic [1:0]        state_o,
    output logic              fault
);

    localparam int SUM_W = LOAD_W + 1;
    localparam int CMP_W = LOAD_W + 6;
    localparam int SET_W = (TMR_CYCLES > 1) ? $clog2(TMR_CYCLES) : 1;
    localparam int OFF_W = (OFF_DBNC > 1) ? $clog2(OFF_DBNC) : 1;

    localparam int GT_THR_I   = MIN_RIDER_WEIGHT + HYSTERESIS;
    localparam int LT_THR_I   = MIN_RIDER_WEIGHT - HYSTERESIS;
    localparam int TMR_LAST_I = TMR_CYCLES - 1;
    localparam int OFF_LAST_I = OFF_DBNC - 1;

    // Thresholds are held one bit wider than the sum so a threshold above
    // the largest possible sum still compares correctly.
    localparam logic [SUM_W:0]   GT_THR   = GT_THR_I[SUM_W:0];
    localparam logic [SUM_W:0]   LT_THR   = LT_THR_I[SUM_W:0];
    localparam logic [SET_W-1:0] TMR_LAST = TMR_LAST_I[SET_W-1:0];
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_LAST_I[OFF_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STEER = 2'd2
    } state_t;

    state_t             r_state;
    logic [SET_W-1:0]   r_settle;
    logic [OFF_W-1:0]   r_off;
    logic               r_en_steer;
    logic               r_rider_off;

    state_t             w_next;
    logic [SET_W-1:0]   w_settle_nxt;
    logic [OFF_W-1:0]   w_off_nxt;

    logic [SUM_W-1:0]   w_sum;
    logic [LOAD_W-1:0]  w_abs_diff;
    logic               w_settle_bad;
    logic [CMP_W-1:0]   w_diff_x16;
    logic [CMP_W-1:0]   w_sum_x15;
    logic               w_step_off;
    logic               w_gt_min;
    logic               w_lt_min;

    // ------------------------------------------------------------------
    // Load-cell arithmetic (all unsigned)
    // ------------------------------------------------------------------
    assign w_sum      = {1'b0, lft_load} + {1'b0, rght_load};
    // Subtract the smaller from the larger so the difference never wraps.
    assign w_abs_diff = (lft_load >= rght_load) ? (lft_load - rght_load)
                                                : (rght_load - lft_load);

    assign w_settle_bad = {1'b0, w_abs_diff} > (w_sum >> SETTLE_SHIFT);

    // Step-off: one side carries more than 15/16 of the total weight.
    // Both products fit in LOAD_W+6 bits, so the comparison is exact.
    assign w_diff_x16 = {2'b00, w_abs_diff, 4'b0000};
    assign w_sum_x15  = ({5'b0, w_sum} << 4) - {5'b0, w_sum};
    assign w_step_off = w_diff_x16 > w_sum_x15;

    // Sums inside the hysteresis band assert neither flag.
    assign w_gt_min = {1'b0, w_sum} > GT_THR;
    assign w_lt_min = {1'b0, w_sum} < LT_THR;

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_settle_nxt = r_settle;
        w_off_nxt    = r_off;

        case (r_state)
            S_IDLE: begin
                w_settle_nxt = '0;
                w_off_nxt    = '0;
                if (w_gt_min) begin
                    w_next = S_WAIT;
                end
            end

            S_WAIT: begin
                // Off counter held at 0 here so every STEER entry starts clean.
                w_off_nxt = '0;
                if (w_lt_min) begin
                    w_next       = S_IDLE;
                    w_settle_nxt = '0;
                end else if (w_settle_bad) begin
                    w_settle_nxt = '0;
                end else if (r_settle == TMR_LAST) begin
                    w_next = S_STEER;
                end else if (r_settle != {SET_W{1'b1}}) begin
                    w_settle_nxt = r_settle + SET_W'(1);
                end
            end

            S_STEER: begin
                w_settle_nxt = '0;
                if (w_lt_min) begin
                    w_next    = S_IDLE;
                    w_off_nxt = '0;
                end else if (w_step_off) begin
                    if (r_off == OFF_LAST) begin
                        w_next    = S_WAIT;
                        w_off_nxt = '0;
                    end else begin
                        w_off_nxt = r_off + OFF_W'(1);
                    end
                end else begin
                    w_off_nxt = '0;
                end
            end

            default: begin
                w_next       = S_IDLE;
                w_settle_nxt = '0;
                w_off_nxt    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_off       <= '0;
            r_en_steer  <= 1'b0;
            r_rider_off <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_settle    <= w_settle_nxt;
            r_off       <= w_off_nxt;
            r_en_steer  <= (w_next == S_STEER);
            // Only a genuine WAIT/STEER -> IDLE drop pulses; an illegal
            // encoding recovering to IDLE does not.
            r_rider_off <= (w_next == S_IDLE) &&
                           ((r_state == S_WAIT) || (r_state == S_STEER));
        end
    end

    assign en_steer  = r_en_steer;
    assign rider_off = r_rider_off;
    assign state_o   = r_state;

`ifdef STEER_FAULT_EN
    localparam int FLT_W = $clog2(FAULT_CYCLES + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FAULT_CYCLES[FLT_W-1:0];

    logic [FLT_W-1:0] r_fcnt;
    logic             r_fault;
    logic [FLT_W-1:0] w_fcnt_nxt;
    logic             w_fault_nxt;

    // Dwell count runs only while staying in WAIT and saturates at the limit.
    always_comb begin
        w_fcnt_nxt  = '0;
        w_fault_nxt = r_fault;
        if ((r_state == S_WAIT) && (w_next == S_WAIT)) begin
            w_fcnt_nxt = (r_fcnt == FLT_LAST) ? r_fcnt : (r_fcnt + FLT_W'(1));
        end
        if (w_next == S_IDLE) begin
            w_fault_nxt = 1'b0;
        end else if (w_fcnt_nxt == FLT_LAST) begin
            w_fault_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_fcnt  <= w_fcnt_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign fault = r_fault;
`else
    localparam bit unused_fault_cfg = (FAULT_CYCLES > 0);
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_steer_en_ctrl.sv
// ----------------------------------------------------------------------------
// tb_steer_en_ctrl
//
// Directed bench for steer_en_ctrl with LOAD_W=12, MIN='h200, HYST='h020,
// SETTLE_SHIFT=2, TMR_CYCLES=16, OFF_DBNC=4, FAULT_CYCLES=64.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_steer_en_ctrl;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_load;
    logic [11:0] rght_load;
    logic        en_steer;
    logic        rider_off;
    logic [1:0]  state_o;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] STEER = 2'd2;

`ifdef STEER_FAULT_EN
    localparam logic FAULT_ON = 1'b1;
`else
    localparam logic FAULT_ON = 1'b0;
`endif

    steer_en_ctrl #(
        .LOAD_W           (12),
        .MIN_RIDER_WEIGHT ('h200),
        .HYSTERESIS       ('h020),
        .SETTLE_SHIFT     (2),
        .TMR_CYCLES       (16),
        .OFF_DBNC         (4),
        .FAULT_CYCLES     (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_load  (lft_load),
        .rght_load (rght_load),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .state_o   (state_o),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [11:0] l, input logic [11:0] r);
        lft_load  = l;
        rght_load = r;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] st);
        chk({tag, "_state"}, {30'd0, state_o}, {30'd0, st});
        chk({tag, "_en"},    {31'd0, en_steer}, {31'd0, (st == STEER)});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(12'h000, 12'h000);
        tick(2);
        chk_state("reset", IDLE);
        chk("reset_ro",    {31'd0, rider_off}, 32'd0);
        chk("reset_fault", {31'd0, fault},     32'd0);

        // Sum exactly at nominal: inside the band, no rider detected.
        rst_n = 1'b1;
        drive(12'h100, 12'h100);
        tick(3);
        chk_state("band_idle", IDLE);
        chk("band_ro", {31'd0, rider_off}, 32'd0);

        // Above band: WAIT next edge, STEER 16 edges later.
        drive(12'h120, 12'h120);
        tick(1);
        chk_state("enter_wait", WAIT);
        tick(15);
        chk_state("settle_15", WAIT);
        tick(1);
        chk_state("settle_16", STEER);

        // Step-off for 3 cycles then rebalance: debounce holds STEER.
        drive(12'h230, 12'h010);
        tick(3);
        chk_state("stepoff_3", STEER);
        drive(12'h120, 12'h120);
        tick(1);
        chk_state("stepoff_reb", STEER);

        // Step-off for 4 cycles: drop to WAIT.
        drive(12'h230, 12'h010);
        tick(3);
        chk_state("stepoff4_3", STEER);
        tick(1);
        chk_state("stepoff4_4", WAIT);
        chk("stepoff_ro", {31'd0, rider_off}, 32'd0);

        // Settle restart: imbalance at WAIT cycle 10.
        drive(12'h120, 12'h120);
        tick(10);
        chk_state("restart_c10", WAIT);
        drive(12'h1A0, 12'h0A0);
        tick(1);
        chk_state("restart_bad", WAIT);
        drive(12'h120, 12'h120);
        tick(15);
        chk_state("restart_15", WAIT);
        tick(1);
        chk_state("restart_16", STEER);

        // Sum in band while steering: stay in STEER.
        drive(12'h0F8, 12'h0F8);
        tick(3);
        chk_state("off_band", STEER);
        chk("off_band_ro", {31'd0, rider_off}, 32'd0);

        // Below band: IDLE and a single rider_off pulse.
        drive(12'h0E0, 12'h0E0);
        tick(1);
        chk_state("off_idle", IDLE);
        chk("off_ro_1", {31'd0, rider_off}, 32'd1);
        tick(1);
        chk_state("off_idle2", IDLE);
        chk("off_ro_2", {31'd0, rider_off}, 32'd0);

        // Reset mid-WAIT: immediate abort, then a full fresh settle.
        drive(12'h120, 12'h120);
        tick(1);
        chk_state("rst_wait", WAIT);
        tick(7);
        chk_state("rst_wait7", WAIT);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("rst_async", IDLE);
        chk("rst_async_ro",    {31'd0, rider_off}, 32'd0);
        chk("rst_async_fault", {31'd0, fault},     32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk_state("rst_rewait", WAIT);
        chk("rst_rewait_ro", {31'd0, rider_off}, 32'd0);
        tick(15);
        chk_state("rst_settle15", WAIT);
        tick(1);
        chk_state("rst_settle16", STEER);

        // Dwell in WAIT with persistent imbalance.
        drive(12'h0E0, 12'h0E0);
        tick(1);
        chk_state("flt_pre_idle", IDLE);
        drive(12'h1A0, 12'h0A0);
        tick(1);
        chk_state("flt_wait", WAIT);
        tick(63);
        chk("flt_63", {31'd0, fault}, 32'd0);
        chk_state("flt_63", WAIT);
        tick(1);
        chk("flt_64", {31'd0, fault}, {31'd0, FAULT_ON});
        tick(3);
        chk("flt_sticky", {31'd0, fault}, {31'd0, FAULT_ON});
        chk_state("flt_sticky", WAIT);
        drive(12'h080, 12'h080);
        tick(1);
        chk_state("flt_idle", IDLE);
        chk("flt_clear", {31'd0, fault},     32'd0);
        chk("flt_ro_1",  {31'd0, rider_off}, 32'd1);
        tick(1);
        chk("flt_ro_2",  {31'd0, rider_off}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/steer_en_ctrl.md
Name: steer_en_ctrl

Overview:
Parametrised rider-presence and steering-enable controller for the Segway balance path. Consumes raw left/right load-cell readings from the A2D interface, with thresholds and hysteresis set by parameters. Owns its own settle timer and a step-off debounce counter, so the external timer and its clear/full handshake go away. Drives en_steer to balance_cntrl and a rider_off pulse to the power/auth logic.

Parameters:
LOAD_W, 12, width of each load-cell reading
MIN_RIDER_WEIGHT, 'h200, nominal rider threshold on lft_load+rght_load
HYSTERESIS, 'h020, band half-width: gt_min when sum > MIN+HYST, lt_min when sum < MIN-HYST
SETTLE_SHIFT, 2, imbalance while settling when abs_diff > (sum >> SETTLE_SHIFT)
TMR_CYCLES, 65_000_000, balanced cycles required in WAIT before STEER (1.3 s at 50 MHz)
OFF_DBNC, 4, consecutive step-off cycles required in STEER before dropping to WAIT (>=1)
FAULT_CYCLES, 250_000_000, WAIT dwell limit (used only with STEER_FAULT_EN)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
lft_load  in  LOAD_W  left load cell, unsigned
rght_load  in  LOAD_W  right load cell, unsigned
en_steer  out  1  registered; high while state==STEER
rider_off  out  1  registered one-cycle pulse on any return to IDLE
state_o  out  2  current state: 0=IDLE, 1=WAIT, 2=STEER
fault  out  1  settle-timeout fault; tied 0 without STEER_FAULT_EN

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset: state=IDLE, settle counter=0, off counter=0, fault counter=0, en_steer=0, rider_off=0, fault=0. Reset asserted mid-operation aborts immediately to this condition.
- Arithmetic, all unsigned:
  - sum = lft_load + rght_load, LOAD_W+1 bits.
  - abs_diff = |lft_load - rght_load|, LOAD_W bits, computed without overflow.
  - settle_bad = abs_diff > (sum >> SETTLE_SHIFT).
  - step_off = 16*abs_diff > 15*sum, compared exactly at LOAD_W+6 bits.
  - gt_min and lt_min as defined for HYSTERESIS.
  - Sums inside the hysteresis band assert neither gt_min nor lt_min.
- IDLE: if gt_min, go to WAIT and set settle counter to 0. Otherwise stay in IDLE.
- WAIT, priorities in this order:
  1. lt_min: go to IDLE.
  2. settle_bad: settle counter to 0, stay in WAIT.
  3. settle counter == TMR_CYCLES-1: go to STEER.
  4. Otherwise increment settle counter.
  - Result: STEER is entered exactly TMR_CYCLES balanced cycles after entry to WAIT or after the last imbalance.
- STEER, priorities in this order:
  1. lt_min: go to IDLE, regardless of step_off or the off counter.
  2. step_off with off counter == OFF_DBNC-1: go to WAIT, settle counter to 0.
  3. step_off: increment off counter.
  4. Otherwise off counter to 0.
  - The off counter clears on every entry to STEER.
- Outputs are registered from the next state, so they change on the same edge as the state.
  - rider_off is high for exactly the first cycle in IDLE after WAIT or STEER.
  - rider_off is never asserted on leaving reset.
- Settle counter saturates; it never wraps. Its width is clog2(TMR_CYCLES).
- Illegal state encoding: go to IDLE on the next edge with all outputs 0.

Optional Feature:
STEER_FAULT_EN:
- Defined: a fault counter counts every cycle spent in WAIT, clearing on leaving WAIT.
  - When the count reaches FAULT_CYCLES, fault is set.
  - fault is sticky until the state returns to IDLE, then clears together with the rider_off pulse.
  - STEER entry is unaffected.
- Not defined: no fault counter logic; fault is constant 0.

Test Plan:
All scenarios use LOAD_W=12, MIN='h200, HYST='h020, SETTLE_SHIFT=2, TMR_CYCLES=16, OFF_DBNC=4.
1. Band edge and settle: lft=rght='h100 (sum 'h200) -> stays IDLE. Then lft=rght='h120 (sum 'h240) -> WAIT next edge, then STEER with en_steer=1 exactly 16 cycles later.
2. Settle restart: in WAIT cycle 10, drive lft='h1A0, rght='h0A0 (diff 'h100 > 'h90) for 1 cycle, then rebalance -> STEER exactly 16 cycles after rebalance.
3. Step-off debounce: in STEER, drive lft='h230, rght='h010 (16*'h220 > 15*'h240).
   - Held for 3 cycles then rebalanced -> stays STEER.
   - Held for 4 cycles -> WAIT, en_steer=0.
4. Rider off: in STEER, drive lft=rght='h0F8 (sum 'h1F0, inside band) -> stays STEER. Then 'h0E0 each (sum 'h1C0) -> IDLE next edge, rider_off=1 for exactly one cycle.
5. Reset mid-operation: assert rst_n low at WAIT cycle 7 -> state_o=0, en_steer=rider_off=fault=0 immediately. After release with sum 'h240 -> a full 16-cycle settle.
6. STEER_FAULT_EN with FAULT_CYCLES=64: hold settle_bad in WAIT -> fault=1 after 64 cycles. Drop sum to 'h100 -> IDLE, fault=0, rider_off pulses once.
